// File: rtl/alu_pkg.sv
// Shared definitions for the WISC ALU shift datapath.
// Mode encodings, FSM states and width defaults.
package alu_pkg;

  localparam int SHR_DATA_W  = 16;
  localparam int SHR_SHAMT_W = 4;

  localparam logic [1:0] SHR_SRA  = 2'b00;
  localparam logic [1:0] SHR_SRL  = 2'b01;
  localparam logic [1:0] SHR_ROR  = 2'b10;
  localparam logic [1:0] SHR_PASS = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shr_state_e;

endpackage

// File: rtl/shr_stage.sv
// One fixed-weight right shift/rotate step.
// AMT is the power-of-two distance of this step.
module shr_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = SHR_DATA_W,
  parameter int AMT    = 1
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        mode,
  input  logic              fill,
  output logic [DATA_W-1:0] result
);

  logic [AMT-1:0] fill_bits;

  assign fill_bits = {AMT{fill}};

  // select the vacated-bit source for this mode
  always_comb begin
    result = data;
    unique case (mode)
      SHR_SRA:
        result = {fill_bits,
                  data[DATA_W-1:AMT]};
      SHR_SRL:
        result = {{AMT{1'b0}},
                  data[DATA_W-1:AMT]};
      SHR_ROR:
        result = {data[AMT-1:0],
                  data[DATA_W-1:AMT]};
      SHR_PASS:
        result = data;
      default:
        result = data;
    endcase
  end

endmodule

// File: rtl/shift_right_iter.sv
// Iterative SRA/SRL/ROR unit, one shamt weight per cycle.
// MSB weight first; fixed SHAMT_W-cycle latency.
module shift_right_iter
  import alu_pkg::*;
#(
  parameter int DATA_W  = SHR_DATA_W,
  parameter int SHAMT_W = SHR_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_zero,
  output logic               out_neg
);

  localparam int K_W =
    (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
  localparam logic [K_W-1:0] K_LAST =
    K_W'(SHAMT_W - 1);

  shr_state_e         state_q;
  shr_state_e         state_d;
  logic [DATA_W-1:0]  work_q;
  logic [DATA_W-1:0]  work_d;
  logic [DATA_W-1:0]  res_q;
  logic [SHAMT_W-1:0] shamt_q;
  logic [1:0]         mode_q;
  logic               fill_q;
  logic [K_W-1:0]     k_q;
  logic               accept;
  logic               last_k;
  logic               drain;

  logic [DATA_W-1:0]  stage_out [SHAMT_W];
  logic [DATA_W-1:0]  stage_sel;

  for (genvar g = 0; g < SHAMT_W; g++) begin
    : g_stage
    shr_stage #(
      .DATA_W (DATA_W),
      .AMT    (1 << g)
    ) u_stage (
      .data   (work_q),
      .mode   (mode_q),
      .fill   (fill_q),
      .result (stage_out[g])
    );
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_ready & in_valid;
  assign drain     = out_valid & out_ready;
  assign last_k    = (k_q == '0);

  assign out_data  = res_q;
  assign out_zero  = (res_q == '0);
  assign out_neg   = res_q[DATA_W-1];

  // pick the stage of the current weight, apply if its bit is set
  always_comb begin
    stage_sel = stage_out[k_q];
    work_d    = work_q;
    if (shamt_q[k_q])
      work_d = stage_sel;
  end

  // state sequencing: accept, walk weights, hold until drained
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE):
        if (accept) state_d = SHIFT;
      (state_q == SHIFT):
        if (last_k) state_d = DONE;
      (state_q == DONE):
        if (drain) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // operand latch, stage counter and working register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q  <= '0;
      shamt_q <= '0;
      mode_q  <= SHR_PASS;
      fill_q  <= 1'b0;
      k_q     <= K_LAST;
    end else if (accept) begin
      work_q  <= in_data;
      shamt_q <= in_shamt;
      mode_q  <= in_mode;
      fill_q  <= in_data[DATA_W-1];
      k_q     <= K_LAST;
    end else if (state_q == SHIFT) begin
      work_q  <= work_d;
      if (!last_k)
        k_q <= k_q - 1'b1;
    end
  end

  // result register: loaded on the final stage, held afterwards
  always_ff @(posedge clk) begin
    if (!rst_n)
      res_q <= '0;
    else if (state_q == SHIFT && last_k)
      res_q <= work_d;
  end

endmodule

// File: tb/tb_shift_right_iter.sv
// Directed bench for shift_right_iter.
// Hand-computed vectors plus a whole-shift reference model.
module tb_shift_right_iter;

  localparam logic [1:0] M_SRA  = 2'b00;
  localparam logic [1:0] M_SRL  = 2'b01;
  localparam logic [1:0] M_ROR  = 2'b10;
  localparam logic [1:0] M_PASS = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_shamt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_neg;

  int nvec;
  int nerr;
  int cyc;

  shift_right_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_neg   (out_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_shr(
      input logic [1:0]  m,
      input logic [15:0] d,
      input logic [3:0]  s);
    logic [31:0] dd;
    logic [15:0] r;
    dd = {d, d} >> s;
    unique case (m)
      M_SRA:   r = 16'($signed(d) >>> s);
      M_SRL:   r = d >> s;
      M_ROR:   r = dd[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  // one request, latency and result checks; drains if out_ready
  task automatic run_op(input string tag,
                        input logic [1:0]  m,
                        input logic [15:0] d,
                        input logic [3:0]  s,
                        input logic [15:0] exp);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = ~d;
    in_shamt = ~s;
    in_mode  = ~m;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'd4);
    chk({tag, ".data"}, 32'(out_data), 32'(exp));
    chk({tag, ".zero"}, 32'(out_zero),
        32'(exp == 16'h0));
    chk({tag, ".neg"}, 32'(out_neg), 32'(exp[15]));
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  rs;
    logic [1:0]  rm;
    int          last_acc;
    int          w;
    nvec      = 0;
    nerr      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_shamt  = 4'd3;
    in_mode   = M_SRL;
    out_ready = 1'b1;

    // reset wins over a simultaneous request
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.rdy", 32'(in_ready), 32'd1);
    chk("rst.vld", 32'(out_valid), 32'd0);
    chk("rst.data", 32'(out_data), 32'h0);
    chk("rst.zero", 32'(out_zero), 32'd1);
    chk("rst.neg", 32'(out_neg), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst.nolatch", 32'(out_valid), 32'd0);
    chk("rst.idle", 32'(in_ready), 32'd1);

    run_op("sra8001", M_SRA, 16'h8001, 4'd4, 16'hF800);
    run_op("srl8001", M_SRL, 16'h8001, 4'd4, 16'h0800);
    run_op("srl0001", M_SRL, 16'h0001, 4'd1, 16'h0000);
    run_op("ror1234", M_ROR, 16'h1234, 4'd4, 16'h4123);
    run_op("ror8001", M_ROR, 16'h8001, 4'd15, 16'h0003);
    run_op("passbeef", M_PASS, 16'hBEEF, 4'd7, 16'hBEEF);
    run_op("sra0", M_SRA, 16'h8000, 4'd0, 16'h8000);
    run_op("sra15", M_SRA, 16'h8000, 4'd15, 16'hFFFF);
    run_op("srl15", M_SRL, 16'h8000, 4'd15, 16'h0001);
    run_op("ror0", M_ROR, 16'hA5C3, 4'd0, 16'hA5C3);
    run_op("sra_pos", M_SRA, 16'h7F00, 4'd3, 16'h0FE0);

    // backpressure: result held, new requests ignored
    out_ready = 1'b0;
    run_op("bp", M_ROR, 16'h1234, 4'd4, 16'h4123);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = i[0] ? 1'b0 : 1'b1;
      in_data  = 16'hFFFF ^ 16'(i);
      in_mode  = M_PASS;
      in_shamt = 4'd0;
      chk("bp.data", 32'(out_data), 32'h4123);
      chk("bp.rdy", 32'(in_ready), 32'd0);
      chk("bp.vld", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.rdy2", 32'(in_ready), 32'd1);
    chk("bp.vld2", 32'(out_valid), 32'd0);
    chk("bp.hold", 32'(out_data), 32'h4123);
    run_op("bp.next", M_SRA, 16'h4000, 4'd2, 16'h1000);

    // reset during the k=2 stage abandons the operation
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'h8001;
    in_shamt = 4'd4;
    in_mode  = M_SRA;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid.vld", 32'(out_valid), 32'd0);
    chk("mid.rdy", 32'(in_ready), 32'd1);
    chk("mid.data", 32'(out_data), 32'h0);
    chk("mid.zero", 32'(out_zero), 32'd1);
    repeat (6) @(negedge clk);
    chk("mid.noemit", 32'(out_valid), 32'd0);
    run_op("mid.srl", M_SRL, 16'h00F0, 4'd4, 16'h000F);

    // back-to-back with in_valid held: accepts every 6 cycles
    last_acc = 0;
    @(negedge clk);
    for (int r = 0; r < 8; r++) begin
      rd = 16'($urandom);
      rs = 4'($urandom_range(0, 15));
      rm = 2'($urandom_range(0, 3));
      in_valid = 1'b1;
      in_data  = rd;
      in_shamt = rs;
      in_mode  = rm;
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("b2b.wait", 32'(w < 20), 32'd1);
      @(negedge clk);
      if (r > 0)
        chk("b2b.gap", 32'(cyc - last_acc), 32'd6);
      last_acc = cyc;
      w = 0;
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("b2b.data", 32'(out_data),
          32'(ref_shr(rm, rd, rs)));
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
